fetch_unit: RTL

//  Instruction-fetch stage directly upstream of the instruction memory. Holds the PC,

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage in front of a combinational instruction memory.
//   Holds the PC, presents it as the memory word address, captures the read
//   word into a one-entry IF/ID register and offers it to decode.
//
// Handshake: a staged word is transferred on any rising edge where
//   if_valid & if_ready. While if_valid=1 and if_ready=0, if_inst, if_pc and
//   if_valid hold stable. A redirect is the only event that may drop a staged
//   word before it is accepted.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_addr         word address to instruction memory (the pc register)
//   imem_data         combinational read data for imem_addr
//   stall             suppress capture this cycle
//   halt              move RUN -> HALTED at the next edge
//   redirect_valid    load pc from redirect_addr and flush the staged word
//   redirect_addr     redirect target
//   if_valid/if_inst/if_pc   staged word towards decode
//   if_ready          decode accepts the staged word
//   halted            1 while in HALTED
//   fetch_count       words captured since reset, saturating
module fetch_unit #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              stall,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              if_ready,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              free;
   logic              capture;

   assign imem_addr = pc;
   assign halted    = (state == ST_HALTED);

   // The IF/ID slot can take a new word when empty or when its current
   // occupant leaves this same edge.
   assign free    = !if_valid || if_ready;
   assign capture = (state == ST_RUN) && !halt && !stall && !redirect_valid && free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         pc          <= ADDR_W'(RESET_PC);
         if_valid    <= 1'b0;
         if_inst     <= '0;
         if_pc       <= '0;
         fetch_count <= '0;
      end else begin
         // State and pc: redirect wins over everything, in every state.
         if (redirect_valid) begin
            pc    <= redirect_addr;
            state <= ST_RUN;
         end else begin
            case (state)
               ST_BOOT:   state <= ST_RUN;
               ST_RUN:    if (halt) state <= ST_HALTED;
               ST_HALTED: state <= ST_HALTED;
               default:   state <= ST_BOOT;
            endcase
            if (capture) pc <= pc + ADDR_W'(1);
         end

         // IF/ID register.
         if (redirect_valid) begin
            if_valid <= 1'b0;
         end else if (capture) begin
            if_valid <= 1'b1;
            if_inst  <= imem_data;
            if_pc    <= pc;
            if (fetch_count != {CNT_W{1'b1}})
               fetch_count <= fetch_count + CNT_W'(1);
         end else if (if_ready) begin
            if_valid <= 1'b0;
         end
      end
   end

endmodule
